lfsr_stream_checker: RTL and testbench
======================================

# lfsr_stream_checker

Receive-side checker for the serial LFSR stream. It captures a seed on `Start` and regenerates the expected word by running the same LFSR recurrence for `ROUNDS` iterations. In parallel it deserialises `WIDTH` LSB-first bits qualified by `Valid_In`, then compares the two and reports `Match`/`Error` with a one-cycle `Done` pulse. It sits at the far end of the generator's `OUT`/`Valid` pair, in test and loopback paths.

## Interface
- `WIDTH`, default 4: LFSR and received-word width; must be ≥ 2.
- `ROUNDS`, default 8: number of LFSR iterations before the word is serialised; must be ≥ 1.
- `CLK` input, 1 bit: clock; all state changes on the rising edge.
- `RST` input, 1 bit: reset; asynchronous, active-high.
- `Seed` input, `WIDTH` bits: seed, sampled only with an accepted `Start`.
- `Start` input, 1 bit: begin a check; accepted only in IDLE.
- `Serial_In` input, 1 bit: serial data bit, LSB of the word first.
- `Valid_In` input, 1 bit: `Serial_In` qualifier, one bit per high cycle.
- `Busy` output, 1 bit: high in RUN and CHECK.
- `Done` output, 1 bit: one-cycle pulse when a result is published.
- `Match` output, 1 bit: received word equals expected word.
- `Error` output, 1 bit: received word differs from expected word.
- `Data_Out` output, `WIDTH` bits: received word, published with `Done`.

## Operation
- **Reset:** while `RST` is high, all of the following are cleared:
  - state = IDLE;
  - `Busy`, `Done`, `Match`, `Error` = 0 and `Data_Out` = 0;
  - internal LFSR, receive shift register and both counters = 0.
- **Reset mid-check:** asserting `RST` during a check aborts it immediately. No `Done` is produced.
- **IDLE:**
  - `Start`=1 loads `Seed` into the LFSR, clears both counters and the receive register, clears `Match`/`Error`, and moves to RUN.
  - `Valid_In` is ignored, including in the `Start` cycle.
- **RUN, compute side:**
  - While `rnd_cnt < ROUNDS`, each cycle the LFSR becomes {fb, lfsr[WIDTH-1:1]}, where fb = XOR of lfsr[WIDTH-2:0].
  - `rnd_cnt` increments by 1 and holds at `ROUNDS`.
- **RUN, receive side:**
  - While `bit_cnt < WIDTH` and `Valid_In`=1, the receive register becomes {Serial_In, rx[WIDTH-1:1]} and `bit_cnt` increments.
  - `Valid_In` after `WIDTH` bits have been taken is ignored.
  - Compute and receive progress independently and may complete in the same cycle.
- **RUN → CHECK:** taken on the edge at which both `rnd_cnt == ROUNDS` and `bit_cnt == WIDTH` hold. Conditions are evaluated on the post-update counter values.
- **CHECK:** one cycle, then IDLE. On the exit edge:
  - `Data_Out` = rx;
  - `Match` = (rx == lfsr) and `Error` = ~`Match`;
  - `Done` = 1.
- **Result hold:** `Done` clears on the next edge. `Match`, `Error` and `Data_Out` hold until the next accepted `Start` or reset.
- **Start outside IDLE:** `Start` in RUN or CHECK is ignored. `Start` in the cycle `Done` is high is accepted, since the state is already IDLE.
- **No timeout:** if fewer than `WIDTH` valid bits ever arrive, the block stays in RUN until reset.
- **Counter widths:** `rnd_cnt` is $clog2(ROUNDS+1) bits and `bit_cnt` is $clog2(WIDTH+1) bits. Neither counter wraps.

## Timing
- Edge 0 samples `Start`; RUN holds from edge 0 to edge k.
- k = max(ROUNDS, edge of the `WIDTH`-th accepted valid bit).
- CHECK holds from edge k to edge k+1.
- `Done`=1 between edges k+1 and k+2.
- Minimum Start-to-Done latency is `ROUNDS`+1 edges, reached when all bits arrive by edge `ROUNDS`.
- `Busy` is registered: high from edge 0 to edge k+1.
- Bits presented with `Valid_In` on the edge that sampled `Start` are not captured.

## Configuration
- `LFSR_CHK_STICKY_ERR_EN` defined:
  - `Error` is sticky: once set, it survives subsequent `Start`s and passing checks, and clears only on `RST`.
  - `Match` still reflects each check individually.
- Undefined: `Error` is cleared on each accepted `Start` and reflects only the latest check.

## Test plan
- **Nominal pass:** WIDTH=4, ROUNDS=8, `Seed`=4'b1001, `Start` at edge 0; bits 0,0,1,1 with `Valid_In` at edges 9–12 → `Done` pulse after edge 13, `Match`=1, `Error`=0, `Data_Out`=4'b1100, `Busy` low after edge 13.
- **Corrupted bit:** same seed; bits 1,0,1,1 → `Match`=0, `Error`=1, `Data_Out`=4'b1101.
- **Lockup seed:** `Seed`=4'b0000; bits 0,0,0,0 sent early at edges 1–4 → no `Done` before the CHECK at edge 8; `Done` after edge 9, `Match`=1.
- **Gapped and extra valids:** bits of the 4'b1100 stream spread with idle cycles between them, plus 2 extra valid bits afterward → `Match`=1; extra bits ignored; a `Start` during RUN is ignored and `Seed` is not reloaded.
- **Reset mid-check:** pulse `RST` after 2 bits → all outputs 0, state IDLE, no `Done`; a fresh `Start` with `Seed`=4'b1001 and a full stream → `Match`=1.
- **Sticky error:** a failing check followed by a passing check → with `LFSR_CHK_STICKY_ERR_EN`, `Error`=1 and `Match`=1; without it, `Error`=0 and `Match`=1.

Source files
------------

// File: rtl/lfsr_stream_checker_if.sv
// Bus bundle for lfsr_stream_checker: seed/start, serial input and result.
// Clock and reset stay outside the bundle as plain module ports.
interface lfsr_stream_checker_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] Seed;
    logic             Start;
    logic             Serial_In;
    logic             Valid_In;
    logic             Busy;
    logic             Done;
    logic             Match;
    logic             Error;
    logic [WIDTH-1:0] Data_Out;

    modport master (
        output Seed, Start, Serial_In, Valid_In,
        input  Busy, Done, Match, Error, Data_Out
    );

    modport slave (
        input  Seed, Start, Serial_In, Valid_In,
        output Busy, Done, Match, Error, Data_Out
    );
endinterface

// File: rtl/lfsr_stream_checker.sv
// Receive-side LFSR stream checker: regenerates the expected word and compares.
// Define LFSR_CHK_STICKY_ERR_EN to make Error sticky until reset.
module lfsr_stream_checker #(
    parameter int WIDTH  = 4,
    parameter int ROUNDS = 8
) (
    input logic                  CLK,
    input logic                  RST,
    lfsr_stream_checker_if.slave bus
);
    localparam int RW = $clog2(ROUNDS + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [RW-1:0] RND_MAX = RW'(ROUNDS);
    localparam logic [BW-1:0] BIT_MAX = BW'(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [RW-1:0]    rnd_cnt_q, rnd_cnt_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             match_q, match_d;
    logic             error_q, error_d;
    logic             fb;
    logic             same;

    assign fb   = ^lfsr_q[WIDTH-2:0];
    assign same = (rx_q == lfsr_q);

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        rx_d       = rx_q;
        rnd_cnt_d  = rnd_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        match_d    = match_q;
        error_d    = error_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    lfsr_d    = bus.Seed;
                    rx_d      = '0;
                    rnd_cnt_d = '0;
                    bit_cnt_d = '0;
                    match_d   = 1'b0;
`ifdef LFSR_CHK_STICKY_ERR_EN
                    error_d   = error_q;
`else
                    error_d   = 1'b0;
`endif
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (rnd_cnt_q < RND_MAX) begin
                    lfsr_d    = {fb, lfsr_q[WIDTH-1:1]};
                    rnd_cnt_d = rnd_cnt_q + RW'(1);
                end
                if (bus.Valid_In && (bit_cnt_q < BIT_MAX)) begin
                    rx_d      = {bus.Serial_In, rx_q[WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
                // Both sides must be finished after this edge's updates
                if ((rnd_cnt_d == RND_MAX) && (bit_cnt_d == BIT_MAX))
                    state_d = S_CHECK;
            end
            S_CHECK: begin
                data_out_d = rx_q;
                match_d    = same;
`ifdef LFSR_CHK_STICKY_ERR_EN
                error_d    = error_q | ~same;
`else
                error_d    = ~same;
`endif
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_CHECK);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            lfsr_q     <= '0;
            rx_q       <= '0;
            rnd_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            match_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            rx_q       <= rx_d;
            rnd_cnt_q  <= rnd_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            match_q    <= match_d;
            error_q    <= error_d;
        end
    end

    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Match    = match_q;
    assign bus.Error    = error_q;
    assign bus.Data_Out = data_out_q;
endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed testbench for lfsr_stream_checker (WIDTH=4, ROUNDS=8).
// Expected words are hand-computed from the 4-bit LFSR recurrence.
module tb_lfsr_stream_checker;
    logic CLK;
    logic RST;
    int   checks;
    int   failures;

    lfsr_stream_checker_if #(.WIDTH(4)) bus ();

    lfsr_stream_checker #(
        .WIDTH (4),
        .ROUNDS(8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // One clock: inputs set before the edge, sampled #1 after it
    task automatic cyc(input logic st, input logic [3:0] sd,
                       input logic v, input logic b);
        bus.Start     = st;
        bus.Seed      = sd;
        bus.Valid_In  = v;
        bus.Serial_In = b;
        @(posedge CLK);
        #1;
        bus.Start     = 1'b0;
        bus.Valid_In  = 1'b0;
        bus.Serial_In = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            cyc(1'b0, 4'b0000, 1'b0, 1'b0);
            if (bus.Done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'b0000, 1'b1, w[i]);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        cyc(1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b0, 1'b0);
        checks++;
        if (bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", bus.Busy);
        end
        checks++;
        if (bus.Done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b exp=0", bus.Done);
        end
        checks++;
        if ({bus.Match, bus.Error} !== 2'b00) begin
            failures++;
            $display("FAIL reset_match_err got=%b%b exp=00", bus.Match, bus.Error);
        end
        checks++;
        if (bus.Data_Out !== 4'b0000) begin
            failures++;
            $display("FAIL reset_data got=%b exp=0000", bus.Data_Out);
        end
        RST = 1'b0;
        cyc(1'b0, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_nominal;
        int early;
        early = 0;
        // Valid_In in the Start cycle must not be captured
        cyc(1'b1, 4'b1001, 1'b1, 1'b1);
        for (int e = 1; e <= 8; e++) begin
            cyc(1'b0, 4'b0000, 1'b0, 1'b0);
            if (bus.Done === 1'b1) early++;
        end
        send_word(4'b1100);
        checks++;
        if (early != 0 || bus.Done !== 1'b0) begin
            failures++;
            $display("FAIL nom_early_done got=%0d/%b exp=0/0", early, bus.Done);
        end
        checks++;
        if (bus.Busy !== 1'b1) begin
            failures++;
            $display("FAIL nom_busy_check got=%b exp=1", bus.Busy);
        end
        cyc(1'b0, 4'b0000, 1'b0, 1'b0);
        checks++;
        if (bus.Done !== 1'b1) begin
            failures++;
            $display("FAIL nom_done got=%b exp=1", bus.Done);
        end
        checks++;
        if ({bus.Match, bus.Error} !== 2'b10) begin
            failures++;
            $display("FAIL nom_match_err got=%b%b exp=10", bus.Match, bus.Error);
        end
        checks++;
        if (bus.Data_Out !== 4'b1100) begin
            failures++;
            $display("FAIL nom_data got=%b exp=1100", bus.Data_Out);
        end
        checks++;
        if (bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL nom_busy_end got=%b exp=0", bus.Busy);
        end
        cyc(1'b0, 4'b0000, 1'b0, 1'b0);
        checks++;
        if (bus.Done !== 1'b0 || bus.Match !== 1'b1) begin
            failures++;
            $display("FAIL nom_hold got=done%b match%b exp=done0 match1", bus.Done, bus.Match);
        end
    endtask

    task automatic test_corrupt;
        bit got;
        cyc(1'b1, 4'b1001, 1'b0, 1'b0);
        checks++;
        if (bus.Match !== 1'b0) begin
            failures++;
            $display("FAIL cor_start_clear got=%b exp=0", bus.Match);
        end
        send_word(4'b1101);
        wait_done(20, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL cor_timeout got=no_done exp=done");
        end
        checks++;
        if ({bus.Match, bus.Error} !== 2'b01) begin
            failures++;
            $display("FAIL cor_match_err got=%b%b exp=01", bus.Match, bus.Error);
        end
        checks++;
        if (bus.Data_Out !== 4'b1101) begin
            failures++;
            $display("FAIL cor_data got=%b exp=1101", bus.Data_Out);
        end
    endtask

    task automatic test_lockup;
        int early;
        early = 0;
        cyc(1'b1, 4'b0000, 1'b0, 1'b0);
        for (int e = 1; e <= 8; e++) begin
            cyc(1'b0, 4'b0000, (e <= 4), 1'b0);
            if (bus.Done === 1'b1) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL lock_early_done got=%0d exp=0", early);
        end
        cyc(1'b0, 4'b0000, 1'b0, 1'b0);
        checks++;
        if (bus.Done !== 1'b1 || bus.Match !== 1'b1) begin
            failures++;
            $display("FAIL lock_done got=done%b match%b exp=done1 match1", bus.Done, bus.Match);
        end
        checks++;
        if (bus.Data_Out !== 4'b0000) begin
            failures++;
            $display("FAIL lock_data got=%b exp=0000", bus.Data_Out);
        end
    endtask

    task automatic test_gapped;
        int early;
        early = 0;
        cyc(1'b1, 4'b1001, 1'b0, 1'b0);
        for (int e = 1; e <= 8; e++) begin
            case (e)
                1, 2:    cyc(1'b0, 4'b0000, 1'b1, 1'b0);
                3:       cyc(1'b1, 4'b0000, 1'b0, 1'b0);
                4, 6:    cyc(1'b0, 4'b0000, 1'b1, 1'b1);
                7, 8:    cyc(1'b0, 4'b0000, 1'b1, 1'b1);
                default: cyc(1'b0, 4'b0000, 1'b0, 1'b0);
            endcase
            if (bus.Done === 1'b1) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL gap_early_done got=%0d exp=0", early);
        end
        cyc(1'b0, 4'b0000, 1'b0, 1'b0);
        checks++;
        if (bus.Done !== 1'b1 || bus.Match !== 1'b1) begin
            failures++;
            $display("FAIL gap_done got=done%b match%b exp=done1 match1", bus.Done, bus.Match);
        end
        checks++;
        if (bus.Data_Out !== 4'b1100) begin
            failures++;
            $display("FAIL gap_data got=%b exp=1100", bus.Data_Out);
        end
    endtask

    task automatic test_reset_mid;
        int spurious;
        bit got;
        spurious = 0;
        cyc(1'b1, 4'b1001, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 1'b0);
        RST = 1'b1;
        #2;
        checks++;
        if ({bus.Busy, bus.Done, bus.Match, bus.Error} !== 4'b0000) begin
            failures++;
            $display("FAIL mid_rst_flags got=%b exp=0000",
                     {bus.Busy, bus.Done, bus.Match, bus.Error});
        end
        checks++;
        if (bus.Data_Out !== 4'b0000) begin
            failures++;
            $display("FAIL mid_rst_data got=%b exp=0000", bus.Data_Out);
        end
        #1;
        RST = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 4'b0000, 1'b1, 1'b1);
            if (bus.Done === 1'b1 || bus.Busy === 1'b1) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL mid_idle got=%0d exp=0", spurious);
        end
        cyc(1'b1, 4'b1001, 1'b0, 1'b0);
        send_word(4'b1100);
        wait_done(20, got);
        checks++;
        if (!got || bus.Match !== 1'b1 || bus.Data_Out !== 4'b1100) begin
            failures++;
            $display("FAIL mid_restart got=done%b match%b data%b exp=done1 match1 data1100",
                     got, bus.Match, bus.Data_Out);
        end
    endtask

    task automatic test_sticky;
        bit got;
        logic exp_err;
        RST = 1'b1;
        #3;
        RST = 1'b0;
        cyc(1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b1001, 1'b0, 1'b0);
        send_word(4'b1101);
        wait_done(20, got);
        checks++;
        if (!got || bus.Error !== 1'b1) begin
            failures++;
            $display("FAIL sticky_first got=done%b err%b exp=done1 err1", got, bus.Error);
        end
        cyc(1'b1, 4'b1001, 1'b0, 1'b0);
        send_word(4'b1100);
        wait_done(20, got);
`ifdef LFSR_CHK_STICKY_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        checks++;
        if (!got || bus.Match !== 1'b1 || bus.Error !== exp_err) begin
            failures++;
            $display("FAIL sticky_second got=done%b match%b err%b exp=done1 match1 err%b",
                     got, bus.Match, bus.Error, exp_err);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        RST           = 1'b0;
        bus.Start     = 1'b0;
        bus.Seed      = 4'b0000;
        bus.Valid_In  = 1'b0;
        bus.Serial_In = 1'b0;
        test_reset();
        test_nominal();
        test_corrupt();
        test_lockup();
        test_gapped();
        test_reset_mid();
        test_sticky();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
